// File: rtl/secuenciador_motores.sv
// Three-colour dosing motor sequencer with a 4-deep order FIFO.
// Optional feature: define MOTOR_PAUSE_EN to add a pause input that freezes the running dose.
module secuenciador_motores #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_r,
    input  logic [4:0] req_g,
    input  logic [4:0] req_b,
    input  logic       abort,
`ifdef MOTOR_PAUSE_EN
    input  logic       pause,
`endif
    output logic       motor_r,
    output logic       motor_g,
    output logic       motor_b,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] pending
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN_R, RUN_G, RUN_B, DONE} state_t;

    state_t      state, nxt;
    logic [14:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop;
    logic [4:0]  head_r, head_g, head_b;
    logic [4:0]  dose_r, dose_g, dose_b, cur_dose, unit;
    logic [7:0]  presc;
    logic        in_run, motor_on, hold, last_tick;

    assign req_ready = (count != 3'd4);
    assign pending   = count;
    assign push      = req_valid && req_ready;
    assign pop       = (state == LOAD);
    assign {head_r, head_g, head_b} = fifo_mem[rd_ptr];

`ifdef MOTOR_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {req_r, req_g, req_b};
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // First colour with a non-zero dose; zero doses are skipped without a gap.
    function automatic state_t first_of(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
        if (r != 5'd0)      return RUN_R;
        else if (g != 5'd0) return RUN_G;
        else if (b != 5'd0) return RUN_B;
        else                return DONE;
    endfunction

    always_comb begin
        in_run   = (state == RUN_R) || (state == RUN_G) || (state == RUN_B);
        motor_on = motor_r | motor_g | motor_b;
        case (state)
            RUN_R:   cur_dose = dose_r;
            RUN_G:   cur_dose = dose_g;
            RUN_B:   cur_dose = dose_b;
            default: cur_dose = 5'd0;
        endcase
        // Counters only advance on cycles the motor was actually on, so a pause costs no dose time.
        last_tick = motor_on && (presc == 8'(TICK_DIV - 1)) && (unit == cur_dose - 5'd1);
        nxt = state;
        case (state)
            IDLE:    if (count != 3'd0) nxt = LOAD;
            LOAD:    nxt = first_of(head_r, head_g, head_b);
            RUN_R:   if (abort) nxt = IDLE; else if (last_tick) nxt = first_of(5'd0, dose_g, dose_b);
            RUN_G:   if (abort) nxt = IDLE; else if (last_tick) nxt = first_of(5'd0, 5'd0, dose_b);
            RUN_B:   if (abort) nxt = IDLE; else if (last_tick) nxt = DONE;
            DONE:    nxt = (count != 3'd0) ? LOAD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dose_r  <= '0;
            dose_g  <= '0;
            dose_b  <= '0;
            presc   <= '0;
            unit    <= '0;
            motor_r <= 1'b0;
            motor_g <= 1'b0;
            motor_b <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= nxt;
            motor_r <= (nxt == RUN_R) && !hold;
            motor_g <= (nxt == RUN_G) && !hold;
            motor_b <= (nxt == RUN_B) && !hold;
            busy    <= (nxt != IDLE);
            done    <= (nxt == DONE);
            aborted <= in_run && abort;
            if (state == LOAD) begin
                dose_r <= head_r;
                dose_g <= head_g;
                dose_b <= head_b;
            end
            if (nxt != state) begin
                presc <= '0;
                unit  <= '0;
            end else if (in_run && motor_on) begin
                if (presc == 8'(TICK_DIV - 1)) begin
                    presc <= '0;
                    unit  <= unit + 5'd1;
                end else begin
                    presc <= presc + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_motores.sv
// Bench for secuenciador_motores: vector table plus scoreboard of per-order motor on-times.
module tb_secuenciador_motores;

    logic       clk = 1'b0;
    logic       rst_n, req_valid, req_ready, abort;
    logic [4:0] req_r, req_g, req_b;
    logic       motor_r, motor_g, motor_b, busy, done, aborted;
    logic [2:0] pending;
`ifdef MOTOR_PAUSE_EN
    logic       pause;
`endif

    secuenciador_motores #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_r(req_r), .req_g(req_g), .req_b(req_b), .abort(abort),
`ifdef MOTOR_PAUSE_EN
        .pause(pause),
`endif
        .motor_r(motor_r), .motor_g(motor_g), .motor_b(motor_b),
        .busy(busy), .done(done), .aborted(aborted), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] r, g, b;
        int         er, eg, eb;
        logic [3:0] first;   // {motor_r, motor_g, motor_b, done} two cycles after the push
    } vec_t;
    typedef struct { int er, eg, eb; } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    int   cr = 0, cg = 0, cb = 0, accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_order(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b,
                              input int er, input int eg, input int eb);
        @(negedge clk);
        req_valid = 1'b1; req_r = r; req_g = g; req_b = b;
        sb.push_back(exp_t'{er, eg, eb});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 800; n++) begin
            if (!busy && pending == 3'd0 && sb.size() == 0) return;
            @(negedge clk);
        end
        chk("idle_timeout", {busy, pending}, 0);
    endtask

    task automatic wait_motor(input logic [2:0] mask);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (({motor_r, motor_g, motor_b} & mask) != 3'b000) return;
        end
        chk("motor_timeout", {motor_r, motor_g, motor_b} & mask, mask);
    endtask

    // Scoreboard: accumulate motor on-time per order, compare on done, discard on abort.
    always @(negedge clk) begin
        if (!rst_n) begin
            cr = 0; cg = 0; cb = 0;
        end else begin
            chk("motor_onehot", 32'(int'(motor_r) + int'(motor_g) + int'(motor_b) <= 1), 1);
            cr += int'(motor_r); cg += int'(motor_g); cb += int'(motor_b);
            if (done) begin
                if (sb.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("sb_motor_r_cycles", cr, mon_e.er);
                    chk("sb_motor_g_cycles", cg, mon_e.eg);
                    chk("sb_motor_b_cycles", cb, mon_e.eb);
                end
                cr = 0; cg = 0; cb = 0;
            end
            if (aborted) begin
                if (sb.size() != 0) mon_e = sb.pop_front();
                cr = 0; cg = 0; cb = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0;
        req_r = '0; req_g = '0; req_b = '0;
`ifdef MOTOR_PAUSE_EN
        pause = 1'b0;
`endif
        vecs[0] = '{5'd2,  5'd1, 5'd3, 8,   4,  12, 4'b1000};
        vecs[1] = '{5'd0,  5'd3, 5'd0, 0,   12, 0,  4'b0100};
        vecs[2] = '{5'd0,  5'd0, 5'd0, 0,   0,  0,  4'b0001};
        vecs[3] = '{5'd1,  5'd0, 5'd1, 4,   0,  4,  4'b1000};
        vecs[4] = '{5'd31, 5'd0, 5'd0, 124, 0,  0,  4'b1000};
        vecs[5] = '{5'd0,  5'd0, 5'd2, 0,   0,  8,  4'b0010};

        repeat (3) @(negedge clk);
        chk("rst_motors", {motor_r, motor_g, motor_b}, 0);
        chk("rst_pulses", {busy, done, aborted}, 0);
        chk("rst_pending", pending, 0);
        chk("rst_req_ready", req_ready, 1);

        // Vector 0 is pushed on the very first posedge after reset release.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            @(negedge clk);
            rst_n = 1'b1;
            req_valid = 1'b1; req_r = vecs[i].r; req_g = vecs[i].g; req_b = vecs[i].b;
            sb.push_back(exp_t'{vecs[i].er, vecs[i].eg, vecs[i].eb});
            @(negedge clk);
            req_valid = 1'b0; req_r = 5'd31; req_g = 5'd31; req_b = 5'd31;
            chk("pending_after_push", pending, 1);
            @(negedge clk);
            chk("load_cycle", {busy, motor_r, motor_g, motor_b}, 4'b1000);
            @(negedge clk);
            chk("first_run_cycle", {motor_r, motor_g, motor_b, done}, vecs[i].first);
            if (!done) begin
                for (int n = 0; n < 300 && !done; n++) @(negedge clk);
                chk("done_seen", done, 1);
            end
            @(negedge clk);
            chk("busy_after_done", busy, 0);
        end

        // Queue fills to 4 behind a running order; only the LOAD pop frees a slot.
        wait_idle();
        push_order(5'd3, 5'd0, 5'd0, 12, 0, 0);
        wait_motor(3'b100);
        accepted = 0;
        for (int a = 0; a < 6; a++) begin
            @(negedge clk);
            req_valid = req_ready;
            req_r = 5'(a + 1); req_g = 5'd0; req_b = 5'd1;
            if (req_ready) begin
                sb.push_back(exp_t'{4 * (a + 1), 0, 4});
                accepted++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("full_accepted", accepted, 4);
        chk("full_pending", pending, 4);
        chk("full_req_ready", req_ready, 0);
        for (int n = 0; n < 100 && pending == 3'd4; n++) @(negedge clk);
        chk("pop_pending", pending, 3);
        chk("pop_req_ready", req_ready, 1);
        wait_idle();

        // Abort in the second cycle of RUN_G; abort held through IDLE and LOAD is ignored.
        push_order(5'd1, 5'd2, 5'd0, 4, 8, 0);
        push_order(5'd0, 5'd0, 5'd1, 0, 0, 4);
        wait_motor(3'b010);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_motors", {motor_r, motor_g, motor_b}, 0);
        chk("abort_pulse", {aborted, done, busy}, 3'b100);
        chk("abort_keeps_queue", pending, 1);
        @(negedge clk);
        chk("abort_then_load", {aborted, busy}, 2'b01);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ignored_in_load", {motor_r, motor_g, motor_b, aborted}, 4'b0010);
        wait_idle();

        // Reset in the middle of RUN_B drops the motor at once and empties the queue.
        push_order(5'd0, 5'd0, 5'd3, 0, 0, 12);
        push_order(5'd1, 5'd0, 5'd0, 4, 0, 0);
        wait_motor(3'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_motor_b", motor_b, 0);
        chk("reset_pending", pending, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_pulse_after_reset", {done, aborted, busy}, 0);
        end

`ifdef MOTOR_PAUSE_EN
        // A 7-cycle pause inside RUN_R keeps the total on-time at 8 cycles.
        push_order(5'd2, 5'd0, 5'd0, 8, 0, 0);
        wait_motor(3'b100);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (7) @(negedge clk);
        chk("paused_motor_low", motor_r, 0);
        pause = 1'b0;
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secuenciador_motores.md
SECUENCIADOR_MOTORES -- requirements
Module: secuenciador_motores

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, clock cycles per dose unit (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  order offered this cycle.
REQ-005 SHALL have port req_ready  output  1  order queue can accept.
REQ-006 SHALL have ports req_r, req_g, req_b  input  5 each  dose units per colour.
REQ-007 SHALL have port abort  input  1  cancel the order currently running.
REQ-008 SHALL have ports motor_r, motor_g, motor_b  output  1 each  motor enables.
REQ-009 SHALL have port busy  output  1  high in any state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, order completed.
REQ-011 SHALL have port aborted  output  1  one-cycle pulse, order cancelled.
REQ-012 SHALL have port pending  output  3  orders waiting in queue, 0..4.

Function
REQ-013 SHALL store orders in a 4-entry FIFO; push on posedge when req_valid && req_ready.
REQ-014 SHALL drive req_ready = (pending != 4); a pop in the same cycle does not raise req_ready.
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN_R, RUN_G, RUN_B, DONE.
REQ-016 IDLE -> LOAD when queue non-empty; LOAD pops the head into internal r/g/b registers.
REQ-017 LOAD -> first colour in order R, G, B with non-zero dose; all three zero -> DONE.
REQ-018 RUN_x SHALL hold only motor_x high for exactly dose_x*TICK_DIV cycles, then go to next non-zero colour or DONE.
REQ-019 Zero-dose colours SHALL be skipped with no motor cycle and no idle gap.
REQ-020 SHALL use a prescaler counter (0..TICK_DIV-1) and a 5-bit unit counter, both cleared on every state entry.
REQ-021 DONE SHALL last one cycle with done=1, then -> LOAD if queue non-empty, else IDLE.
REQ-022 At most one motor output SHALL be high in any cycle; motor outputs are registered.
REQ-023 Latency: order accepted at edge k into empty queue with FSM in IDLE -> LOAD in cycle k+1, first motor high in cycle k+2.
REQ-024 abort in a RUN state SHALL drop all motors next cycle, pulse aborted one cycle, discard that order, keep the queue, and go to IDLE.
REQ-025 abort outside RUN states SHALL be ignored; abort and completion in the same cycle -> abort wins, no done.
REQ-026 Dose inputs are sampled only at the push edge; later changes do not affect queued orders.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, empty FIFO, counters 0, and all outputs low except req_ready=1.
REQ-028 Reset mid-run SHALL drop motors asynchronously without a done or aborted pulse.
REQ-029 First push after rst_n deassertion SHALL be accepted on the first posedge.

Configuration
REQ-030 With MOTOR_PAUSE_EN defined, SHALL add input port pause (1 bit).
REQ-031 With MOTOR_PAUSE_EN defined, pause high in a RUN state SHALL lower motors next cycle and freeze both counters; on release, resume with the remaining duration exactly preserved.
REQ-032 Without MOTOR_PAUSE_EN, no pause port SHALL exist and timing SHALL be per REQ-018.

Verification (TICK_DIV=4)
REQ-033 Push R=2,G=1,B=3 at reset idle -> motor_r 8, motor_g 4, motor_b 12 contiguous cycles; done one cycle after motor_b falls; busy low next cycle.
REQ-034 Push R=0,G=3,B=0 -> only motor_g high for 12 cycles; push 0,0,0 -> done pulse in cycle k+2, no motor activity.
REQ-035 Push 6 orders back-to-back during a run -> 4 accepted plus the running order, pending=4, req_ready=0 until the next LOAD pop.
REQ-036 Assert abort in cycle 2 of RUN_G with 1 order queued -> motors low next cycle, aborted=1 for one cycle, no done, queued order starts via IDLE->LOAD.
REQ-037 Pull rst_n low mid RUN_B -> motor_b low before next posedge, pending=0, req_ready=1.
REQ-038 With MOTOR_PAUSE_EN, pause for 7 cycles during RUN_R (R=2) -> motor_r total high time still 8 cycles, split around the pause.
